// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared types for the registered ALU.
// Opcodes, FSM states and the packed status-flag bundle.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_INC = 4'd2,
        OP_DEC = 4'd3,
        OP_INV = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_MUL = 4'd10
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic v;
        logic c;
        logic nf;
        logic z;
    } flags_t;

    localparam int FLAG_V  = 3;
    localparam int FLAG_C  = 2;
    localparam int FLAG_NF = 1;
    localparam int FLAG_Z  = 0;

endpackage

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: N-iteration shift-add unsigned multiplier.
// Ports: start/a/b load a job; done is high for the cycle product is final.
module alu_pipe_mul
    import alu_pipe_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    logic           running;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] prod;

    // The loading edge already performs the first iteration, so the
    // product is final after N edges and can be written on the next one.
    assign done    = running && (cnt == CNT_LAST);
    assign product = prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CW'(1);
            prod    <= b[0] ? {{N{1'b0}}, a} : '0;
            mcand   <= {{(N-1){1'b0}}, a, 1'b0};
            mplier  <= {1'b0, b[N-1:1]};
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    prod <= prod + mcand;
                end
                mcand  <= {mcand[2*N-2:0], 1'b0};
                mplier <= {1'b0, mplier[N-1:1]};
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered N-bit ALU with valid/ready, flags, accumulator, MUL.
// Ports: in_valid/in_ready + A/B/opcode/use_acc in; out_valid/out_ready + Y/flags out; busy.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   opcode,
    input  logic         use_acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic [3:0]   flags,
    output logic         busy
);

    state_e         state_q;
    logic [N-1:0]   acc_q;
    logic [N-1:0]   y_q;
    flags_t         flags_q;
    logic           valid_q;

    logic [N-1:0]   b_eff;
    logic           accept;
    logic           is_mul;
    logic           mul_done;
    logic [2*N-1:0] mul_prod;
    logic           wr_res;

    logic [N:0]     sum_w;
    logic [N-1:0]   sc_y;
    logic           sc_c;
    logic           sc_v;
    logic           sc_legal;

    logic [N-1:0]   res_y;
    flags_t         res_f;

    assign b_eff     = use_acc ? acc_q : B;
    assign in_ready  = !rst && (state_q == IDLE) && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (opcode == OP_MUL);
    assign busy      = (state_q == MUL);
    assign out_valid = valid_q;
    assign Y         = y_q;
    assign flags     = flags_q;

    alu_pipe_mul #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (A),
        .b       (b_eff),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        sum_w    = '0;
        sc_y     = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_legal = 1'b1;
        unique case (opcode)
            OP_ADD: begin
                sum_w = {1'b0, A} + {1'b0, b_eff};
                sc_y  = sum_w[N-1:0];
                sc_c  = sum_w[N];
                sc_v  = (A[N-1] == b_eff[N-1]) && (sc_y[N-1] != A[N-1]);
            end
            OP_SUB: begin
                sc_y = A - b_eff;
                sc_c = (A < b_eff);
                sc_v = (A[N-1] != b_eff[N-1]) && (sc_y[N-1] != A[N-1]);
            end
            OP_INC: begin
                sum_w = {1'b0, A} + (N+1)'(1);
                sc_y  = sum_w[N-1:0];
                sc_c  = sum_w[N];
                sc_v  = !A[N-1] && sc_y[N-1];
            end
            OP_DEC: begin
                sc_y = A - N'(1);
                sc_c = (A == '0);
                sc_v = A[N-1] && !sc_y[N-1];
            end
            OP_INV: sc_y = ~A;
            OP_AND: sc_y = A & b_eff;
            OP_OR:  sc_y = A | b_eff;
            OP_XOR: sc_y = A ^ b_eff;
            OP_SHL: begin
                sc_y = {A[N-2:0], 1'b0};
                sc_c = A[N-1];
            end
            OP_SHR: begin
                sc_y = {1'b0, A[N-1:1]};
                sc_c = A[0];
            end
            // MUL is finished by the multiplier; 11..15 are illegal.
            default: sc_legal = 1'b0;
        endcase
    end

    // Illegal ops fall through with Y=0, which yields flags 0001.
    always_comb begin
        res_y   = '0;
        res_f   = '0;
        if (state_q == MUL) begin
            res_y   = mul_prod[N-1:0];
            res_f.c = |mul_prod[2*N-1:N];
        end else if (sc_legal) begin
            res_y   = sc_y;
            res_f.c = sc_c;
            res_f.v = sc_v;
        end
        res_f.z  = (res_y == '0);
        res_f.nf = res_y[N-1];
    end

    assign wr_res = (accept && !is_mul) || ((state_q == MUL) && mul_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_res) begin
                y_q     <= res_y;
                flags_q <= res_f;
                acc_q   <= res_y;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE:    if (accept && is_mul) state_q <= MUL;
                MUL:     if (mul_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table + scoreboard bench for alu_pipe (N=8).
// Hand sequences cover reset, MUL timing, back-pressure and reset mid-MUL.
module tb_alu_pipe;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   opcode;
    logic         use_acc;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Y;
    logic [3:0]   flags;
    logic         busy;

    alu_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .flags     (flags),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ua;
        logic [N-1:0] y;
        logic [3:0]   f;
    } vec_t;

    int n_assert = 0;
    int n_fail   = 0;
    logic [N+3:0] exp_q[$];
    vec_t tbl[24];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [N+3:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb Y", 32'(Y), 32'(e[N+3:4]));
                chk("sb flags", 32'(flags), 32'(e[3:0]));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic ua,
                        input logic [N-1:0] ey, input logic [3:0] ef);
        int waits;
        opcode   = op;
        A        = a;
        B        = b;
        use_acc  = ua;
        in_valid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            chk("accept timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back({ey, ef});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        opcode    = '0;
        use_acc   = 1'b0;
        out_ready = 1'b1;

        tbl[0]  = '{4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b1010};
        tbl[1]  = '{4'd1,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b0110};
        tbl[2]  = '{4'd3,  8'h00, 8'h00, 1'b0, 8'hFF, 4'b0110};
        tbl[3]  = '{4'd2,  8'hFF, 8'h00, 1'b0, 8'h00, 4'b0101};
        tbl[4]  = '{4'd2,  8'h7F, 8'h00, 1'b0, 8'h80, 4'b1010};
        tbl[5]  = '{4'd1,  8'h80, 8'h01, 1'b0, 8'h7F, 4'b1000};
        tbl[6]  = '{4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b0101};
        tbl[7]  = '{4'd4,  8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0010};
        tbl[8]  = '{4'd5,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
        tbl[9]  = '{4'd6,  8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b0010};
        tbl[10] = '{4'd7,  8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0001};
        tbl[11] = '{4'd8,  8'h81, 8'h00, 1'b0, 8'h02, 4'b0100};
        tbl[12] = '{4'd9,  8'h81, 8'h00, 1'b0, 8'h40, 4'b0100};
        tbl[13] = '{4'd3,  8'h80, 8'h00, 1'b0, 8'h7F, 4'b1000};
        tbl[14] = '{4'd0,  8'h05, 8'h03, 1'b0, 8'h08, 4'b0000};
        tbl[15] = '{4'd0,  8'h02, 8'hEE, 1'b1, 8'h0A, 4'b0000};
        tbl[16] = '{4'd12, 8'h33, 8'h44, 1'b0, 8'h00, 4'b0001};
        tbl[17] = '{4'd0,  8'h01, 8'hEE, 1'b1, 8'h01, 4'b0000};
        tbl[18] = '{4'd10, 8'h10, 8'h11, 1'b0, 8'h10, 4'b0100};
        tbl[19] = '{4'd10, 8'h0F, 8'h0F, 1'b0, 8'hE1, 4'b0010};
        tbl[20] = '{4'd10, 8'h03, 8'h00, 1'b1, 8'hA3, 4'b0110};
        tbl[21] = '{4'd1,  8'h05, 8'h05, 1'b0, 8'h00, 4'b0001};
        tbl[22] = '{4'd1,  8'h03, 8'h05, 1'b0, 8'hFE, 4'b0110};
        tbl[23] = '{4'd15, 8'h12, 8'h34, 1'b0, 8'h00, 4'b0001};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst Y", 32'(Y), 32'd0);
        chk("rst flags", 32'(flags), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // single-cycle latency
        send(4'd0, 8'h11, 8'h22, 1'b0, 8'h33, 4'b0000);
        @(negedge clk);
        chk("latency out_valid", 32'(out_valid), 32'd1);
        idle(1);

        // vector table, back-to-back with out_ready high
        for (int i = 0; i < 24; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua,
                 tbl[i].y, tbl[i].f);
        end
        idle(3);

        // MUL timing: result exactly N edges after accept
        send(4'd10, 8'h07, 8'h09, 1'b0, 8'h3F, 4'b0000);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("mul busy", 32'(busy), 32'd1);
            chk("mul in_ready", 32'(in_ready), 32'd0);
            chk("mul out_valid early", 32'(out_valid), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("mul out_valid", 32'(out_valid), 32'd1);
        chk("mul busy clear", 32'(busy), 32'd0);
        idle(2);

        // back-pressure: hold result, stall second operand
        out_ready = 1'b0;
        send(4'd0, 8'h20, 8'h22, 1'b0, 8'h42, 4'b0000);
        opcode   = 4'd1;
        A        = 8'h10;
        B        = 8'h30;
        use_acc  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp Y", 32'(Y), 32'h42);
            chk("bp flags", 32'(flags), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp accept", 32'(in_ready), 32'd1);
        exp_q.push_back({8'hE0, 4'b0110});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp out_valid kept", 32'(out_valid), 32'd1);
        chk("bp Y second", 32'(Y), 32'hE0);
        idle(2);

        // reset in the middle of a multiply
        send(4'd10, 8'h05, 8'h05, 1'b0, 8'h19, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort Y", 32'(Y), 32'd0);
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("abort no stale", 32'(out_valid), 32'd0);
        end
        idle(1);
        send(4'd0, 8'h01, 8'hEE, 1'b1, 8'h01, 4'b0000);
        idle(3);
        chk("queue drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
